// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared heading encodings and helpers for the snake game
// Contents: dir_t (one-hot heading), DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT,
//           DIR_RESET, and opposite() which maps a heading to its reverse.
package snake_pkg;

    typedef logic [3:0] dir_t;

    localparam dir_t DIR_UP    = 4'b1000;
    localparam dir_t DIR_DOWN  = 4'b0100;
    localparam dir_t DIR_LEFT  = 4'b0010;
    localparam dir_t DIR_RIGHT = 4'b0001;
    localparam dir_t DIR_RESET = DIR_DOWN;

    // Non one-hot inputs have no reverse; zero never matches a real press.
    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_UP:    opposite = DIR_DOWN;
            DIR_DOWN:  opposite = DIR_UP;
            DIR_LEFT:  opposite = DIR_RIGHT;
            DIR_RIGHT: opposite = DIR_LEFT;
            default:   opposite = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - per-button synchronizer, debouncer and rising-edge detector
// Parameters: DEB_CYCLES - stable cycles needed before the debounced level moves (>=2)
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   btn_i   in  raw asynchronous button level
//   rise_o  out one-cycle pulse when the debounced level goes 0->1
module btn_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic rise_o
);

    localparam int              CNT_W   = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d;
    logic             deb_dly_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronized input disagrees with the
    // debounced level; any agreeing sample restarts the stability window.
    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_MAX) begin
                deb_d = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= btn_i;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            cnt_q     <= cnt_d;
        end
    end

    assign rise_o = deb_q & ~deb_dly_q;

endmodule

// File: rtl/direction_queue.sv
// rtl/direction_queue.sv - debounced direction buttons feeding a turn FIFO for the snake heading
// Optional feature macro: DIRQ_DROP_CNT_EN (adds drop_cnt output)
// Parameters: DEPTH (1..8) turn FIFO entries, DEB_CYCLES debounce window
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   btn[3:0]   in  raw buttons [3]=up [2]=down [1]=left [0]=right
//   step       in  game tick pulse, pops one queued turn
//   clear      in  synchronous new-game flush (debounce state untouched)
//   direction  out current one-hot heading
//   pending    out number of queued turns
//   drop_cnt   out saturating count of valid presses lost to a full FIFO (macro only)
module direction_queue
    import snake_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int DEB_CYCLES = 500000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [3:0]                   btn,
    input  logic                         step,
    input  logic                         clear,
    output logic [3:0]                   direction,
    output logic [$clog2(DEPTH+1)-1:0]   pending
`ifdef DIRQ_DROP_CNT_EN
    ,
    output logic [7:0]                   drop_cnt
`endif
);

    localparam int                PEND_W    = $clog2(DEPTH + 1);
    localparam int                PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);

    logic [3:0]        rise;
    dir_t              fifo_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, tail_idx;
    logic [PEND_W-1:0] pending_q, pending_d;
    dir_t              direction_q, ref_dir;
    logic              press_ok, accept, full, do_pop, do_push, do_drop;

    for (genvar i = 0; i < 4; i++) begin : g_deb
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_i  (btn[i]),
            .rise_o (rise[i])
        );
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        tail_idx  = (wr_ptr_q == '0) ? PTR_LAST : wr_ptr_q - 1'b1;
        // Exactly one rising edge: simultaneous rises are treated as noise.
        press_ok  = (rise != 4'd0) && ((rise & (rise - 4'd1)) == 4'd0);
        // New presses are judged against the last queued turn, not the
        // current heading, so a burst of taps can't build a reversal.
        ref_dir   = (pending_q != '0) ? fifo_q[tail_idx] : direction_q;
        accept    = press_ok && (rise != ref_dir) && (rise != opposite(ref_dir));
        full      = (pending_q == PEND_FULL);
        do_pop    = step && (pending_q != '0);
        // A full queue still takes a press when the same cycle frees a slot.
        do_push   = accept && (!full || do_pop);
        do_drop   = accept && full && !do_pop;
        pending_d = pending_q;
        if (do_push && !do_pop) begin
            pending_d = pending_q + 1'b1;
        end else if (do_pop && !do_push) begin
            pending_d = pending_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= DIR_RESET;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pending_q   <= '0;
            direction_q <= DIR_RESET;
        end else if (clear) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pending_q   <= '0;
            direction_q <= DIR_RESET;
        end else begin
            // On full push+pop, wr_ptr equals rd_ptr; the pop reads the old
            // value before the new entry lands in that slot.
            if (do_push) begin
                fifo_q[wr_ptr_q] <= rise;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                direction_q <= fifo_q[rd_ptr_q];
                rd_ptr_q    <= ptr_inc(rd_ptr_q);
            end
            pending_q <= pending_d;
        end
    end

    assign direction = direction_q;
    assign pending   = pending_q;

`ifdef DIRQ_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= 8'd0;
        end else if (clear) begin
            drop_cnt_q <= 8'd0;
        end else if (do_drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = do_drop;
`endif

endmodule
